adder4_sweep_checker: RTL and testbench

//  Self-checking operand sequencer and result checker for the bit4Adder datapath.

---
 rtl/adder4_sweep_checker.sv | 135 +++++++++++++
 tb/tb_adder4_sweep_checker.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/adder4_sweep_checker.sv
// rtl/adder4_sweep_checker.sv - exhaustive operand sweep and result checker for a WIDTH-bit adder
module adder4_sweep_checker #(
   parameter int WIDTH  = 4,
   parameter int SETTLE = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_start,
   output logic [WIDTH-1:0]   o_a,
   output logic [WIDTH-1:0]   o_b,
   input  logic [WIDTH-1:0]   i_s,
   input  logic               i_cout,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_pass,
   output logic [2*WIDTH:0]   o_err_count,
   output logic [WIDTH-1:0]   o_first_err_a,
   output logic [WIDTH-1:0]   o_first_err_b
);

   localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic               w_launch;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic [CW-1:0]      r_settle;
   logic [2*WIDTH:0]   r_err;
   logic [WIDTH-1:0]   r_fe_a;
   logic [WIDTH-1:0]   r_fe_b;
   logic               r_busy;
   logic               r_done;
   logic               r_pass;
   logic [WIDTH:0]     w_sum;
   logic               w_mismatch;
   logic               w_last;
   logic [2*WIDTH:0]   w_err_next;

   assign w_sum      = {1'b0, r_a} + {1'b0, r_b};
   assign w_mismatch = ({i_cout, i_s} != w_sum);
   assign w_last     = &{r_a, r_b};
   // Saturating increment; only the CHECK state ever commits it.
   assign w_err_next = !w_mismatch ? r_err : ((&r_err) ? r_err : r_err + 1'b1);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_launch     = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               w_launch     = 1'b1;
               w_next_state = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_settle == CW'(1)) begin
               w_next_state = S_CHECK;
            end
         end
         S_CHECK: begin
            w_next_state = w_last ? S_DONE : S_WAIT;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_settle <= '0;
         r_err    <= '0;
         r_fe_a   <= '0;
         r_fe_b   <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
      end else if (w_launch) begin
         r_a      <= '0;
         r_b      <= '0;
         r_settle <= CW'(SETTLE);
         r_err    <= '0;
         r_fe_a   <= '0;
         r_fe_b   <= '0;
         r_busy   <= 1'b1;
         r_done   <= 1'b0;
         r_pass   <= 1'b0;
      end else begin
         case (r_state)
            S_WAIT: r_settle <= r_settle - 1'b1;
            S_CHECK: begin
               r_err <= w_err_next;
               if (w_mismatch && (r_err == '0)) begin
                  r_fe_a <= r_a;
                  r_fe_b <= r_b;
               end
               if (w_last) begin
                  r_busy <= 1'b0;
                  r_done <= 1'b1;
                  r_pass <= (w_err_next == '0);
               end else begin
                  // B is the inner loop; A advances when B wraps.
                  r_b      <= r_b + 1'b1;
                  r_settle <= CW'(SETTLE);
                  if (&r_b) begin
                     r_a <= r_a + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_a           = r_a;
   assign o_b           = r_b;
   assign o_busy        = r_busy;
   assign o_done        = r_done;
   assign o_pass        = r_pass;
   assign o_err_count   = r_err;
   assign o_first_err_a = r_fe_a;
   assign o_first_err_b = r_fe_b;

endmodule

// File: tb/tb_adder4_sweep_checker.sv
// tb/tb_adder4_sweep_checker.sv - bench for adder4_sweep_checker with a fault-injectable adder model
module tb_adder4_sweep_checker;

   localparam int W     = 4;
   localparam int ST    = 2;
   localparam int NV    = 256;
   localparam int SWEEP = NV * (ST + 1);

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [3:0]  a, b, s, fa, fb;
   logic        cout, busy, done, pass;
   logic [8:0]  err;

   int          mode;
   logic [255:0] bad_mask;
   logic [4:0]  w_true, sum5;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   adder4_sweep_checker #(.WIDTH(W), .SETTLE(ST)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
      .o_a(a), .o_b(b), .i_s(s), .i_cout(cout),
      .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_count(err),
      .o_first_err_a(fa), .o_first_err_b(fb)
   );

   // Adder under test: golden, S[0] stuck-at-0, cout stuck-at-0, or S[0] flipped on masked pairs
   assign w_true = {1'b0, a} + {1'b0, b};
   always_comb begin
      sum5 = w_true;
      if (mode == 1)                              sum5 = w_true & 5'b11110;
      else if (mode == 2)                         sum5 = w_true & 5'b01111;
      else if (mode == 3 && bad_mask[{a, b}])     sum5 = w_true ^ 5'b00001;
   end
   assign s    = sum5[3:0];
   assign cout = sum5[4];

   typedef struct {
      int           mode;
      logic [255:0] mask;
      int           pulse_at;
      int           exp_err;
      int           exp_fa;
      int           exp_fb;
      int           exp_pass;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: walk every operand pair in sweep order and classify it from the fault description
   task automatic model(input int m, input logic [255:0] mask,
                        output int e, output int f_a, output int f_b);
      bit bad;
      e = 0; f_a = 0; f_b = 0;
      for (int x = 0; x < 16; x++) begin
         for (int y = 0; y < 16; y++) begin
            case (m)
               1:       bad = ((x + y) % 2) != 0;
               2:       bad = (x + y) > 15;
               3:       bad = mask[x * 16 + y];
               default: bad = 0;
            endcase
            if (bad) begin
               if (e == 0) begin f_a = x; f_b = y; end
               e++;
            end
         end
      end
   endtask

   task automatic run_sweep(input int pulse_at);
      int seq_bad;
      int done_at;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      check("start_busy", busy, 1);
      check("start_done_clr", done, 0);
      check("start_err_clr", err, 0);
      check("start_ab", {a, b}, 0);
      seq_bad = 0;
      done_at = -1;
      for (int k = 1; k <= SWEEP + 50 && done_at < 0; k++) begin
         if (k == pulse_at) start = 1'b1;
         @(posedge clk); #1 start = 1'b0;
         if (done) done_at = k;
         else if (k < SWEEP && (busy !== 1'b1 || {a, b} != 8'(k / (ST + 1)))) seq_bad++;
      end
      check("sequence", seq_bad, 0);
      check("done_latency", done_at, SWEEP);
      check("done_busy_low", busy, 0);
      check("done_ab_hold", {a, b}, 8'hFF);
   endtask

   vec_t vecs[5];
   int   e_m, fa_m, fb_m;

   initial begin
      vecs[0] = '{0, 256'd0,         100, 0,   0, 0, 1};
      vecs[1] = '{1, 256'd0,         -1,  128, 0, 1, 0};
      vecs[2] = '{2, 256'd0,         -1,  120, 1, 15, 0};
      vecs[3] = '{3, 256'd1,         -1,  1,   0, 0, 0};
      vecs[4] = '{3, 256'd1 << 255,  -1,  1,   15, 15, 0};

      mode = 0; bad_mask = '0; start = 1'b0; rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_ab", {a, b}, 0);
      check("rst_err", err, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1 check("idle_no_start", busy, 0);

      foreach (vecs[i]) begin
         mode = vecs[i].mode;
         bad_mask = vecs[i].mask;
         run_sweep(vecs[i].pulse_at);
         check($sformatf("tbl%0d_err", i), err, vecs[i].exp_err);
         check($sformatf("tbl%0d_fa", i), fa, vecs[i].exp_fa);
         check($sformatf("tbl%0d_fb", i), fb, vecs[i].exp_fb);
         check($sformatf("tbl%0d_pass", i), pass, vecs[i].exp_pass);
      end

      repeat (5) @(posedge clk);
      #1;
      check("done_hold", done, 1);
      check("done_err_hold", err, 1);

      for (int t = 0; t < 3; t++) begin
         mode = 3;
         for (int j = 0; j < 256; j++) bad_mask[j] = ($urandom_range(0, 15) == 0);
         model(mode, bad_mask, e_m, fa_m, fb_m);
         run_sweep(-1);
         check($sformatf("rnd%0d_err", t), err, e_m);
         check($sformatf("rnd%0d_fa", t), fa, fa_m);
         check($sformatf("rnd%0d_fb", t), fb, fb_m);
         check($sformatf("rnd%0d_pass", t), pass, (e_m == 0));
      end

      // Reset asynchronously in the middle of a sweep
      mode = 1;
      @(negedge clk) start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      repeat (300) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_busy", busy, 0);
      check("midrst_done", done, 0);
      check("midrst_pass", pass, 0);
      check("midrst_ab", {a, b}, 0);
      check("midrst_err", err, 0);
      check("midrst_fe", {fa, fb}, 0);
      @(posedge clk); #1;
      check("midrst_held", busy, 0);
      @(negedge clk) rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("post_rst_idle", busy, 0);
      mode = 0;
      run_sweep(-1);
      check("post_rst_pass", pass, 1);
      check("post_rst_err", err, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
